intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl.sv | 121 ++++++++++++
 tb/tb_intersection_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Two-street intersection light controller with pedestrian walk phase.
// Six-phase cycle; main street rests on green until a side car or walker asks.
module intersection_ctrl #(
    parameter int GREEN_MIN = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int SIDE_T    = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_green,
    output logic       main_yellow,
    output logic       main_red,
    output logic       side_green,
    output logic       side_yellow,
    output logic       side_red,
    output logic       ped_walk,
    output logic [2:0] state,
    output logic [4:0] count
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [4:0] G_LAST = 5'(GREEN_MIN - 1);
    localparam logic [4:0] Y_LAST = 5'(YELLOW_T - 1);
    localparam logic [4:0] A_LAST = 5'(ALLRED_T - 1);
    localparam logic [4:0] S_LAST = 5'(SIDE_T - 1);

    state_t     cur;
    state_t     succ;
    state_t     nxt;
    logic       adv;
    logic       ped_pending;
    logic [6:0] lamps;

    // {main g,y,r, side g,y,r, walk}; unknown codes show red both ways
    function automatic logic [6:0] decode(state_t s);
        case (s)
            MG:      decode = 7'b1000010;
            MY:      decode = 7'b0100010;
            AR1:     decode = 7'b0010010;
            SG:      decode = 7'b0011001;
            SY:      decode = 7'b0010100;
            AR2:     decode = 7'b0010010;
            default: decode = 7'b0010010;
        endcase
    endfunction

    always_comb begin
        adv  = 1'b0;
        succ = MG;
        case (cur)
            MG: begin
                adv  = (count >= G_LAST) && (side_req || ped_pending);
                succ = MY;
            end
            MY: begin
                adv  = (count == Y_LAST);
                succ = AR1;
            end
            AR1: begin
                adv  = (count == A_LAST);
                succ = SG;
            end
            SG: begin
                adv  = (count == S_LAST);
                succ = SY;
            end
            SY: begin
                adv  = (count == Y_LAST);
                succ = AR2;
            end
            AR2: begin
                adv  = (count == A_LAST);
                succ = MG;
            end
            default: begin
                adv  = 1'b1;
                succ = MG;
            end
        endcase
        nxt = adv ? succ : cur;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur         <= MG;
            count       <= 5'd0;
            ped_pending <= 1'b0;
        end else begin
            if (enable) begin
                cur <= nxt;
                if (adv)
                    count <= 5'd0;
                else if (count != 5'd31)
                    count <= count + 5'd1;
            end
            // Entering the walk phase serves the request, even one arriving now
            if (enable && adv && nxt == SG)
                ped_pending <= 1'b0;
            else if (ped_req && cur != SG)
                ped_pending <= 1'b1;
        end
    end

    assign lamps = decode(cur);
    assign state = cur;
    assign {main_green, main_yellow, main_red,
            side_green, side_yellow, side_red, ped_walk} = lamps;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: fixed vector table, corner sequences,
// and random traffic checked against a phase/duration model.
module tb_intersection_ctrl;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int A = 2;
    localparam int S = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       main_green, main_yellow, main_red;
    logic       side_green, side_yellow, side_red;
    logic       ped_walk;
    logic [2:0] state;
    logic [4:0] count;

    intersection_ctrl #(
        .GREEN_MIN(G), .YELLOW_T(Y), .ALLRED_T(A), .SIDE_T(S)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .side_req(side_req), .ped_req(ped_req),
        .main_green(main_green), .main_yellow(main_yellow),
        .main_red(main_red), .side_green(side_green),
        .side_yellow(side_yellow), .side_red(side_red),
        .ped_walk(ped_walk), .state(state), .count(count)
    );

    always #5 clock = ~clock;

    int ms, mc;
    bit mp;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit en;
        bit side;
        bit ped;
        int st;
        int cnt;
    } vec_t;
    vec_t tab[$];

    function automatic int dur(int s);
        case (s)
            1, 4:    return Y;
            2, 5:    return A;
            3:       return S;
            default: return 0;
        endcase
    endfunction

    // {main g,y,r, side g,y,r, walk} per phase
    function automatic logic [6:0] lamps_of(int s);
        case (s)
            0:       return 7'b1000010;
            1:       return 7'b0100010;
            3:       return 7'b0011001;
            4:       return 7'b0010100;
            default: return 7'b0010010;
        endcase
    endfunction

    task automatic check(string name, int es, int ec);
        logic [6:0] got;
        logic [6:0] el;
        got = {main_green, main_yellow, main_red,
               side_green, side_yellow, side_red, ped_walk};
        el = lamps_of(es);
        n_vec++;
        if (state !== 3'(es) || count !== 5'(ec) || got !== el) begin
            n_err++;
            $display("FAIL %s: got state=%0d count=%0d lamps=%b, want state=%0d count=%0d lamps=%b",
                     name, state, count, got, es, ec, el);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic model_edge(bit en, bit side, bit ped);
        bit leave;
        int ns;
        bit enter_sg;
        leave = 0;
        enter_sg = 0;
        ns = ms;
        if (en) begin
            if (ms == 0)
                leave = (mc >= G - 1) && (side || mp);
            else
                leave = (mc == dur(ms) - 1);
            if (leave) begin
                ns = (ms + 1) % 6;
                enter_sg = (ns == 3);
            end
        end
        if (enter_sg)
            mp = 0;
        else if (ped && ms != 3)
            mp = 1;
        if (en) begin
            if (leave)
                mc = 0;
            else if (mc < 31)
                mc = mc + 1;
        end
        ms = ns;
    endtask

    task automatic step(bit en, bit side, bit ped, string name);
        enable = en;
        side_req = side;
        ped_req = ped;
        @(posedge clock);
        model_edge(en, side, ped);
        #1;
        check(name, ms, mc);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ped_req = 1'b0;
        #1;
        ms = 0;
        mc = 0;
        mp = 0;
        check("async_reset", ms, mc);
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic void seg(bit en, bit side, int st, int c0, int c1);
        vec_t v;
        for (int c = c0; c <= c1; c++) begin
            v.en = en;
            v.side = side;
            v.ped = 0;
            v.st = st;
            v.cnt = c;
            tab.push_back(v);
        end
    endfunction

    initial begin
        int walk;
        int sg;
        int frozen;
        bit en;

        // Full period with a side car waiting from reset release
        seg(1, 1, 0, 1, 7);
        seg(1, 1, 1, 0, 2);
        seg(1, 1, 2, 0, 1);
        seg(1, 1, 3, 0, 5);
        seg(1, 1, 4, 0, 2);
        seg(1, 1, 5, 0, 1);
        seg(1, 1, 0, 0, 0);
        seg(0, 1, 0, 0, 0);
        seg(0, 1, 0, 0, 0);
        seg(0, 1, 0, 0, 0);
        seg(1, 1, 0, 1, 3);

        do_reset();
        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].en, tab[i].side, tab[i].ped, "table_model");
            check("table_vec", tab[i].st, tab[i].cnt);
        end

        // Pedestrian pulse at MG count 2, no side traffic
        do_reset();
        step(1, 0, 0, "ped_seq");
        step(1, 0, 0, "ped_seq");
        step(1, 0, 1, "ped_seq");
        walk = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, "ped_seq");
            if (ped_walk === 1'b1)
                walk++;
        end
        check_val("ped_walk_cycles", walk, 6);
        for (int i = 0; i < 40; i++)
            step(1, 0, 0, "ped_rest");
        check_val("ped_cleared_mg", int'(state), 0);

        // Idle main street saturates its counter
        do_reset();
        for (int i = 0; i < 100; i++)
            step(1, 0, 0, "idle");
        check_val("idle_count_sat", int'(count), 31);
        check_val("idle_main_green", int'(main_green), 1);

        // Freeze for 5 cycles at SG count 2
        do_reset();
        sg = 0;
        frozen = 0;
        for (int i = 0; i < 50; i++) begin
            en = 1;
            if (ms == 3 && mc == 2 && frozen < 5) begin
                en = 0;
                frozen++;
            end
            step(en, (ms == 0) && i < 20, 0, "freeze");
            if (state === 3'd3)
                sg++;
        end
        check_val("freeze_done", frozen, 5);
        check_val("sg_cycles", sg, 11);

        // Reset mid side-yellow with a walker pending
        do_reset();
        for (int i = 0; i < 40 && !(ms == 4 && mc == 0); i++)
            step(1, 1, 0, "to_sy");
        check_val("reached_sy", ms == 4 && mc == 0 ? 1 : 0, 1);
        step(1, 0, 1, "sy_ped");
        check_val("at_sy1", int'(count), 1);
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, "post_reset");
        check_val("reset_drop_ped", int'(state), 0);

        // Walk requests on the SG entry edge and inside SG are both dropped
        do_reset();
        for (int i = 0; i < 40 && !(ms == 2 && mc == 1); i++)
            step(1, 1, 0, "to_ar1");
        check_val("reached_ar1", ms == 2 && mc == 1 ? 1 : 0, 1);
        step(1, 0, 1, "sg_entry_ped");
        for (int i = 0; i < 60; i++)
            step(1, 0, (ms == 3 && mc == 3), "sg_ped");
        check_val("sg_ped_ignored", int'(state), 0);
        check_val("sg_ped_sat", int'(count), 31);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0)
                do_reset();
            else
                step($urandom_range(9) != 0, $urandom_range(4) == 0,
                     $urandom_range(19) == 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
